taillight_decoder: RTL and testbench
====================================

TAILLIGHT_DECODER -- requirements
Module: taillight_decoder

Interface
REQ-001 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-002 reset_n  input  1  synchronous, active-low reset.
REQ-003 tick  input  1  one-CLOCK_50-cycle strobe, one per light step (1 Hz in system use).
REQ-004 LL  input  3  left lamp pattern; bit0 innermost.
REQ-005 RL  input  3  right lamp pattern; bit0 innermost.
REQ-006 mode  output  2  decoded mode: IDLE=0, LEFT=1, RIGHT=2, HAZARD=3.
REQ-007 seq_done  output  1  one-cycle pulse when a full legal sequence completes.
REQ-008 err  output  1  one-cycle pulse on an illegal step.
REQ-009 err_count  output  8  saturating illegal-step counter.

Function
REQ-010 The block SHALL sample {LL,RL} only in cycles where tick=1; non-tick cycles SHALL hold all state.
REQ-011 The legal step chains SHALL be:
- IDLE {000,000}->{000,000}
- LEFT {000,000}->{001,000}->{011,000}->{111,000}->{000,000}
- RIGHT {000,000}->{000,001}->{000,011}->{000,111}->{000,000}
- HAZARD {000,000}->{111,111}->{000,000}
REQ-012 FSM states SHALL be: S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HZ, S_ERR.
REQ-013 From S_IDLE, a sampled {001,000}/{000,001}/{111,111}/{000,000} SHALL move to S_L1/S_R1/S_HZ/S_IDLE respectively.
REQ-014 S_L1->S_L2->S_L3 and S_R1->S_R2->S_R3 SHALL advance only on the next chain pattern.
REQ-015 S_L3, S_R3 and S_HZ SHALL go to S_IDLE on {000,000} and SHALL pulse seq_done the cycle after that tick.
REQ-016 Any other sampled pattern SHALL be illegal: err pulses the cycle after the tick, and err_count increments, saturating at 255.
REQ-017 After an illegal step, the FSM SHALL resync: to S_L1, S_R1 or S_HZ if the sampled pattern is that first step, to S_IDLE on {000,000}, otherwise to S_ERR.
REQ-018 In S_ERR, {000,000} SHALL go to S_IDLE without err; any other pattern SHALL stay in S_ERR and count as illegal.
REQ-019 mode SHALL update on entry to S_L1/S_R1/S_HZ, SHALL hold through the sequence, and SHALL return to IDLE only after two consecutive {000,000} samples.
REQ-020 In S_ERR, mode SHALL be IDLE.
REQ-021 Output latency SHALL be one CLOCK_50 cycle after the sampling tick; seq_done and err SHALL never assert in the same cycle.

Reset
REQ-022 reset_n=0 at a rising edge SHALL force S_IDLE, mode=IDLE, seq_done=0, err=0, err_count=0, and clear the idle-run counter.
REQ-023 reset_n=0 SHALL take priority over a simultaneous tick; the first tick after release SHALL be evaluated from S_IDLE.

Configuration
REQ-024 With TLDEC_ERRCOUNT_EN defined, err_count SHALL behave per REQ-016.
REQ-025 Without TLDEC_ERRCOUNT_EN, err_count SHALL be constant 0 and no counter register SHALL exist; err is unaffected.

Structure
REQ-026 Package taillight_pkg SHALL hold the mode enum, the FSM state enum, and pattern constants (P_OFF=000, P_1=001, P_2=011, P_3=111).
REQ-027 One sub-module, tl_pattern_classify, SHALL combinationally map {LL,RL} to a pattern class: OFF, L1, L2, L3, R1, R2, R3, HZ, BAD.

Verification
REQ-028 Reset, then ticks with {000,000},{001,000},{011,000},{111,000},{000,000} -> mode=LEFT from the 2nd tick; seq_done pulses once after the 5th; err never asserts.
REQ-029 Ticks with {000,000},{111,111},{000,000},{111,111} -> mode=HAZARD throughout; seq_done pulses after the 3rd tick.
REQ-030 Tick with {001,000}, then {111,000} -> err pulses once; err_count=1; FSM in S_ERR; mode=IDLE.
REQ-031 Complete a RIGHT sequence, then two {000,000} ticks -> mode returns to IDLE only after the 2nd idle tick.
REQ-032 Assert reset_n=0 mid-sequence in S_L2, coincident with a tick -> next cycle all outputs are 0; the next tick with {011,000} gives err=1.
REQ-033 Apply 300 illegal ticks of {101,010} -> err_count saturates at 255 with TLDEC_ERRCOUNT_EN defined, and stays 0 without it.

Source files
------------

// File: rtl/taillight_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : taillight_pkg
//  Purpose  : Shared types and constants for the tail-light sequence decoder:
//             decoded mode, FSM state, lamp pattern class and lamp patterns.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package taillight_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_t;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_L1   = 4'd1,
        S_L2   = 4'd2,
        S_L3   = 4'd3,
        S_R1   = 4'd4,
        S_R2   = 4'd5,
        S_R3   = 4'd6,
        S_HZ   = 4'd7,
        S_ERR  = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        PC_OFF = 4'd0,
        PC_L1  = 4'd1,
        PC_L2  = 4'd2,
        PC_L3  = 4'd3,
        PC_R1  = 4'd4,
        PC_R2  = 4'd5,
        PC_R3  = 4'd6,
        PC_HZ  = 4'd7,
        PC_BAD = 4'd8
    } pclass_t;

    localparam logic [2:0] P_OFF = 3'b000;
    localparam logic [2:0] P_1   = 3'b001;
    localparam logic [2:0] P_2   = 3'b011;
    localparam logic [2:0] P_3   = 3'b111;

    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    // Where the FSM lands after an illegal step: a pattern that is itself the
    // first step of a chain restarts that chain, all-off goes idle, anything
    // else parks in the error state until the lamps go dark.
    function automatic state_t resync_state(input pclass_t pc);
        case (pc)
            PC_OFF:  return S_IDLE;
            PC_L1:   return S_L1;
            PC_R1:   return S_R1;
            PC_HZ:   return S_HZ;
            default: return S_ERR;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_pattern_classify.sv
`default_nettype none
// ============================================================================
//  Module   : tl_pattern_classify
//  Purpose  : Combinational map of the two lamp banks onto a pattern class.
//  Ports    : LL     in  [2:0]  left lamp pattern, bit0 innermost
//             RL     in  [2:0]  right lamp pattern, bit0 innermost
//             pclass out        OFF, L1..L3, R1..R3, HZ or BAD
//  Revision : 1.0  initial release
// ============================================================================
module tl_pattern_classify
    import taillight_pkg::*;
(
    input  logic [2:0] LL,
    input  logic [2:0] RL,
    output pclass_t    pclass
);

    always_comb begin
        pclass = PC_BAD;
        if (LL == P_OFF) begin
            case (RL)
                P_OFF:   pclass = PC_OFF;
                P_1:     pclass = PC_R1;
                P_2:     pclass = PC_R2;
                P_3:     pclass = PC_R3;
                default: pclass = PC_BAD;
            endcase
        end else if (RL == P_OFF) begin
            case (LL)
                P_1:     pclass = PC_L1;
                P_2:     pclass = PC_L2;
                P_3:     pclass = PC_L3;
                default: pclass = PC_BAD;
            endcase
        end else if ((LL == P_3) && (RL == P_3)) begin
            pclass = PC_HZ;
        end
    end

endmodule
`default_nettype wire

// File: rtl/taillight_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : taillight_decoder
//  Purpose  : Tracks tail-light lamp patterns sampled on tick strobes, decodes
//             the signalling mode and flags completed / illegal sequences.
//  Ports    : CLOCK_50  in        system clock (rising edge)
//             reset_n   in        synchronous active-low reset
//             tick      in        one-cycle sampling strobe
//             LL, RL    in  [2:0] left / right lamp patterns
//             mode      out [1:0] IDLE=0 LEFT=1 RIGHT=2 HAZARD=3
//             seq_done  out       pulse: legal sequence completed
//             err       out       pulse: illegal step
//             err_count out [7:0] saturating illegal-step count
//  Config   : TLDEC_ERRCOUNT_EN - when defined, err_count is a live
//             saturating counter; otherwise it is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module taillight_decoder
    import taillight_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [2:0] LL,
    input  logic [2:0] RL,
    output logic [1:0] mode,
    output logic       seq_done,
    output logic       err,
    output logic [7:0] err_count
);

    pclass_t    w_pclass;
    state_t     r_state;
    state_t     w_next_state;
    mode_t      r_mode;
    mode_t      w_next_mode;
    logic [1:0] r_idle_run;
    logic [1:0] w_idle_run_next;
    logic       r_seq_done;
    logic       w_seq_done;
    logic       r_err;
    logic       w_err;
    logic       w_illegal;

    tl_pattern_classify u_classify (
        .LL     (LL),
        .RL     (RL),
        .pclass (w_pclass)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_mode     <= MODE_IDLE;
            r_idle_run <= 2'd0;
            r_seq_done <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_mode     <= w_next_mode;
            r_idle_run <= w_idle_run_next;
            r_seq_done <= w_seq_done;
            r_err      <= w_err;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_mode     = r_mode;
        w_idle_run_next = r_idle_run;
        w_seq_done      = 1'b0;
        w_err           = 1'b0;
        w_illegal       = 1'b0;

        if (tick) begin
            // Consecutive all-off samples, saturating at two.
            if (w_pclass == PC_OFF) begin
                w_idle_run_next = (r_idle_run == 2'd2) ? 2'd2 : r_idle_run + 2'd1;
            end else begin
                w_idle_run_next = 2'd0;
            end

            case (r_state)
                S_IDLE: begin
                    case (w_pclass)
                        PC_OFF:  w_next_state = S_IDLE;
                        PC_L1:   w_next_state = S_L1;
                        PC_R1:   w_next_state = S_R1;
                        PC_HZ:   w_next_state = S_HZ;
                        default: w_illegal    = 1'b1;
                    endcase
                end
                S_L1: if (w_pclass == PC_L2) w_next_state = S_L2; else w_illegal = 1'b1;
                S_L2: if (w_pclass == PC_L3) w_next_state = S_L3; else w_illegal = 1'b1;
                S_R1: if (w_pclass == PC_R2) w_next_state = S_R2; else w_illegal = 1'b1;
                S_R2: if (w_pclass == PC_R3) w_next_state = S_R3; else w_illegal = 1'b1;
                S_L3, S_R3, S_HZ: begin
                    if (w_pclass == PC_OFF) begin
                        w_next_state = S_IDLE;
                        w_seq_done   = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                S_ERR: begin
                    // Only a dark lamp set leaves the error state; nothing
                    // here resyncs onto a chain start.
                    if (w_pclass == PC_OFF) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_ERR;
                        w_err        = 1'b1;
                    end
                end
                default: w_illegal = 1'b1;
            endcase

            if (w_illegal) begin
                w_err        = 1'b1;
                w_next_state = resync_state(w_pclass);
            end

            // Mode changes only on chain entry, on entering the error state,
            // or after the lamps have been dark for two samples in a row.
            case (w_next_state)
                S_L1:  w_next_mode = MODE_LEFT;
                S_R1:  w_next_mode = MODE_RIGHT;
                S_HZ:  w_next_mode = MODE_HAZARD;
                S_ERR: w_next_mode = MODE_IDLE;
                default: begin
                    if (w_idle_run_next == 2'd2) begin
                        w_next_mode = MODE_IDLE;
                    end
                end
            endcase
        end
    end

    assign mode     = r_mode;
    assign seq_done = r_seq_done;
    assign err      = r_err;

`ifdef TLDEC_ERRCOUNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_err_count <= 8'd0;
        end else if (w_err && (r_err_count != ERR_COUNT_MAX)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_taillight_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_taillight_decoder
//  Purpose  : Self-checking bench for taillight_decoder. Directed tick
//             vectors push hand-computed expectations into a queue; a monitor
//             pops and compares one cycle after every sampled tick, checks
//             that outputs hold between ticks, and checks reset values.
//  Config   : honours TLDEC_ERRCOUNT_EN for the expected err_count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_taillight_decoder;

`ifdef TLDEC_ERRCOUNT_EN
    localparam bit c_cnt_on = 1'b1;
`else
    localparam bit c_cnt_on = 1'b0;
`endif

    typedef struct {
        int         idx;
        logic [1:0] mode;
        logic       sd;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic       CLOCK_50;
    logic       reset_n;
    logic       tick;
    logic [2:0] LL;
    logic [2:0] RL;
    logic [1:0] mode;
    logic       seq_done;
    logic       err;
    logic [7:0] err_count;

    exp_t exp_q[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   n_steps = 0;
    int   exp_cnt = 0;

    taillight_decoder dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .tick      (tick),
        .LL        (LL),
        .RL        (RL),
        .mode      (mode),
        .seq_done  (seq_done),
        .err       (err),
        .err_count (err_count)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic chk(input string nm, input int idx, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", nm, idx, act, req);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t last;
        exp_t x;
        logic s_tick;
        logic s_rst;
        last = '{idx: -1, mode: 2'd0, sd: 1'b0, err: 1'b0, cnt: 8'd0};
        forever begin
            @(posedge CLOCK_50);
            s_tick = tick;
            s_rst  = reset_n;
            #1;
            if (!s_rst) begin
                chk("reset_mode", -1, int'(mode), 0);
                chk("reset_seq_done", -1, int'(seq_done), 0);
                chk("reset_err", -1, int'(err), 0);
                chk("reset_err_count", -1, int'(err_count), 0);
                last = '{idx: -1, mode: 2'd0, sd: 1'b0, err: 1'b0, cnt: 8'd0};
            end else if (s_tick) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tick", -1, 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    chk("mode", x.idx, int'(mode), int'(x.mode));
                    chk("seq_done", x.idx, int'(seq_done), int'(x.sd));
                    chk("err", x.idx, int'(err), int'(x.err));
                    chk("err_count", x.idx, int'(err_count), int'(x.cnt));
                    last = x;
                end
            end else begin
                chk("hold_mode", last.idx, int'(mode), int'(last.mode));
                chk("hold_seq_done", last.idx, int'(seq_done), 0);
                chk("hold_err", last.idx, int'(err), 0);
                chk("hold_err_count", last.idx, int'(err_count), int'(last.cnt));
            end
        end
    end

    // Called at a falling edge; returns at a falling edge.
    task automatic step(input logic [2:0] ll, input logic [2:0] rl,
                        input logic [1:0] m, input logic sd, input logic e,
                        input int gap);
        exp_t x;
        LL   = ll;
        RL   = rl;
        tick = 1'b1;
        if (e && exp_cnt != 255) exp_cnt++;
        x.idx  = n_steps;
        x.mode = m;
        x.sd   = sd;
        x.err  = e;
        x.cnt  = c_cnt_on ? 8'(exp_cnt) : 8'd0;
        n_steps++;
        exp_q.push_back(x);
        @(negedge CLOCK_50);
        tick = 1'b0;
        repeat (gap) @(negedge CLOCK_50);
    endtask

    task automatic rst_pulse(input logic with_tick, input logic [2:0] ll, input logic [2:0] rl);
        reset_n = 1'b0;
        tick    = with_tick;
        LL      = ll;
        RL      = rl;
        exp_cnt = 0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        tick    = 1'b0;
        @(negedge CLOCK_50);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        tick    = 1'b0;
        LL      = 3'b000;
        RL      = 3'b000;
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(negedge CLOCK_50);

        // LEFT chain: mode LEFT from 2nd tick, seq_done after 5th
        step(3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1);
        step(3'b001, 3'b000, 2'd1, 1'b0, 1'b0, 1);
        step(3'b011, 3'b000, 2'd1, 1'b0, 1'b0, 2);
        step(3'b111, 3'b000, 2'd1, 1'b0, 1'b0, 1);
        step(3'b000, 3'b000, 2'd1, 1'b1, 1'b0, 1);

        // HAZARD, then two dark samples return mode to IDLE
        rst_pulse(1'b0, 3'b000, 3'b000);
        step(3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1);
        step(3'b111, 3'b111, 2'd3, 1'b0, 1'b0, 1);
        step(3'b000, 3'b000, 2'd3, 1'b1, 1'b0, 1);
        step(3'b111, 3'b111, 2'd3, 1'b0, 1'b0, 1);
        step(3'b000, 3'b000, 2'd3, 1'b1, 1'b0, 1);
        step(3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1);

        // RIGHT chain back-to-back, idle only after second dark sample
        step(3'b000, 3'b001, 2'd2, 1'b0, 1'b0, 0);
        step(3'b000, 3'b011, 2'd2, 1'b0, 1'b0, 0);
        step(3'b000, 3'b111, 2'd2, 1'b0, 1'b0, 0);
        step(3'b000, 3'b000, 2'd2, 1'b1, 1'b0, 0);
        step(3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1);

        // Illegal L1 -> L3 parks in S_ERR; L1 there is still illegal
        step(3'b001, 3'b000, 2'd1, 1'b0, 1'b0, 1);
        step(3'b111, 3'b000, 2'd0, 1'b0, 1'b1, 1);
        step(3'b001, 3'b000, 2'd0, 1'b0, 1'b1, 1);
        step(3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1);

        // Resync onto a chain start after an illegal step
        step(3'b001, 3'b000, 2'd1, 1'b0, 1'b0, 1);
        step(3'b000, 3'b001, 2'd2, 1'b0, 1'b1, 1);
        step(3'b000, 3'b000, 2'd2, 1'b0, 1'b1, 1);
        step(3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1);

        // Reset coincident with a tick while in S_L2
        step(3'b001, 3'b000, 2'd1, 1'b0, 1'b0, 1);
        step(3'b011, 3'b000, 2'd1, 1'b0, 1'b0, 1);
        rst_pulse(1'b1, 3'b111, 3'b000);
        step(3'b011, 3'b000, 2'd0, 1'b0, 1'b1, 1);
        step(3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1);

        // 300 illegal ticks: counter saturates (or stays 0)
        for (int i = 0; i < 300; i++) begin
            step(3'b101, 3'b010, 2'd0, 1'b0, 1'b1, 0);
        end
        step(3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 1);

        repeat (3) @(negedge CLOCK_50);
        chk("queue_drained", -1, exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
